// File: rtl/uart_tx.sv
// 8-bit UART transmitter with CTS flow control: start bit, 8 data bits LSB first, STOP_BITS stops.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_cts_n,
  output logic       o_tx,
  output logic       o_busy
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  localparam logic [15:0] BitReload = 16'(CLKS_PER_BIT - 1);
  localparam logic        StopLast  = 1'(STOP_BITS - 1);

  state_e      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_stop_idx;
  logic        r_tx;
  logic        r_busy;
  logic        r_armed;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic w_ready;
  logic w_bit_done;

  // r_armed keeps o_ready low until the first clock edge after reset release.
  assign w_ready    = r_armed & (r_state == StIdle) & ~i_cts_n;
  assign w_bit_done = (r_cnt == 16'd0);
  assign o_ready    = w_ready;
  assign o_tx       = r_tx;
  assign o_busy     = r_busy;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_cnt      <= 16'd0;
      r_idx      <= 3'd0;
      r_shift    <= 8'd0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        StIdle: begin
          if (i_valid && w_ready) begin
            r_state <= StStart;
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= BitReload;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^i_data;
`endif
          end
        end
        StStart: begin
          if (w_bit_done) begin
            r_state <= StData;
            r_tx    <= r_shift[0];
            r_idx   <= 3'd0;
            r_cnt   <= BitReload;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StData: begin
          if (w_bit_done) begin
            r_cnt <= BitReload;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= StParity;
              r_tx    <= r_parity;
`else
              r_state    <= StStop;
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
`endif
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_bit_done) begin
            r_state    <= StStop;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_cnt      <= BitReload;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        StStop: begin
          if (w_bit_done) begin
            if (r_stop_idx == StopLast) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_stop_idx <= 1'b1;
              r_cnt      <= BitReload;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random bytes, CTS, back-to-back and reset cases.
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int SB  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       cts_n = 1'b0;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;
  int w;
  bit prev_hold;

  typedef struct {
    logic [7:0] data;
    bit         hold;
    int         cts_at;
  } vec_t;

  vec_t vecs[9];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .i_data (data),
    .i_valid(valid),
    .o_ready(o_ready),
    .i_cts_n(cts_n),
    .o_tx   (o_tx),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Present a byte and wait (bounded) for the handshake; returns at the negedge of frame cycle 0.
  task automatic start_frame(input logic [7:0] d, input bit hold, output int waited);
    data   = d;
    valid  = 1'b1;
    waited = 0;
    #1;
    while (o_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (o_ready !== 1'b1) begin
      check("handshake_timeout", o_ready, 1'b1);
      valid  = 1'b0;
      waited = -1;
      return;
    end
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  // Reference frame: list of line levels, each held CPB cycles.
  task automatic send_frame(input logic [7:0] d, input bit hold, input int cts_at,
                            output int waited);
    bit exp_bits[$];
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^d);
`endif
    for (int s = 0; s < SB; s++) exp_bits.push_back(1'b1);
    start_frame(d, hold, waited);
    for (int c = 0; c < exp_bits.size() * CPB; c++) begin
      if (c == cts_at) cts_n = 1'b1;
      check($sformatf("tx byte %02h cyc %0d", d, c), o_tx, exp_bits[c / CPB]);
      check($sformatf("busy byte %02h cyc %0d", d, c), o_busy, 1'b1);
      if (!hold) data = 8'($urandom);
      @(negedge clk);
    end
    check($sformatf("idle_tx after %02h", d), o_tx, 1'b1);
    check($sformatf("idle_busy after %02h", d), o_busy, 1'b0);
    check($sformatf("idle_ready after %02h", d), o_ready, ~cts_n);
    cts_n = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, -1};
    vecs[1] = '{8'h55, 1'b1, -1};
    vecs[2] = '{8'h0F, 1'b0, -1};
    vecs[3] = '{8'hFF, 1'b0, -1};
    vecs[4] = '{8'h00, 1'b0, -1};
    vecs[5] = '{8'h80, 1'b0, 20};
    vecs[6] = '{8'h01, 1'b0, -1};
    vecs[7] = '{8'h07, 1'b0, -1};
    vecs[8] = '{8'h03, 1'b0, -1};

    // Reset held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", o_tx, 1'b1);
      check("rst_busy", o_busy, 1'b0);
      check("rst_ready", o_ready, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", o_ready, 1'b1);
    check("post_rst_tx", o_tx, 1'b1);
    check("post_rst_busy", o_busy, 1'b0);

    // Table vectors
    prev_hold = 1'b0;
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].data, vecs[v].hold, vecs[v].cts_at, w);
      if (prev_hold) check($sformatf("b2b_no_gap vec %0d", v), (w == 0), 1'b1);
      prev_hold = vecs[v].hold;
    end

    // CTS hold-off
    cts_n = 1'b1;
    valid = 1'b1;
    data  = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("cts_hold_ready", o_ready, 1'b0);
      check("cts_hold_tx", o_tx, 1'b1);
      check("cts_hold_busy", o_busy, 1'b0);
    end
    cts_n = 1'b0;
    send_frame(8'h3C, 1'b0, -1, w);
    check("cts_release_immediate", (w == 0), 1'b1);

    // Reset during data bit 3 of 0x00
    start_frame(8'h00, 1'b0, w);
    repeat (17) @(negedge clk);
    check("pre_abort_tx", o_tx, 1'b0);
    check("pre_abort_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_tx", o_tx, 1'b1);
    check("abort_busy", o_busy, 1'b0);
    check("abort_ready", o_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("after_abort_tx", o_tx, 1'b1);
      check("after_abort_busy", o_busy, 1'b0);
    end
    check("after_abort_ready", o_ready, 1'b1);

    // Randomized frames against the reference model
    prev_hold = 1'b0;
    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      bit         h;
      int         ca;
      d  = 8'($urandom);
      h  = (r != 23) && ($urandom_range(0, 3) == 0);
      ca = (!h && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 35)) : -1;
      send_frame(d, h, ca, w);
      if (prev_hold) check($sformatf("rand_b2b %0d", r), (w == 0), 1'b1);
      prev_hold = h;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
